// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write bus of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master(output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave(input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles a checksummed little-endian byte stream into
// instruction-memory writes and holds the core in reset until the image verifies.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus,
    input  logic         load_req,
    output logic         core_reset_n,
    output logic         load_done,
    output logic         load_err
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR} state_t;
    state_t state, state_n;
    logic [15:0] cnt, hdr_n;
    logic [ADDR_W:0] widx;
    logic [1:0] bcnt;
    logic [31:0] asm_q;
    logic [7:0] xsum;
    logic acc, word_end, restart;
    assign bus.in_ready = state inside {HDR0, HDR1, DATA, CSUM};
    always_comb begin
        acc      = bus.in_valid & bus.in_ready;
        hdr_n    = {bus.in_data, cnt[7:0]};
        word_end = acc && state == DATA && bcnt == 2'd3;
        restart  = (state == DONE || state == ERROR) && load_req;
        state_n  = state;
        case (state)
            IDLE:        state_n = HDR0;
            HDR0:        state_n = acc ? HDR1 : HDR0;
            HDR1:        state_n = !acc ? HDR1 : ({16'd0, hdr_n} > (32'd1 << ADDR_W)) ? ERROR :
                                   (hdr_n == 16'd0) ? CSUM : DATA;
            DATA:        state_n = (word_end && 16'(widx) + 16'd1 == cnt) ? CSUM : DATA;
            CSUM:        state_n = !acc ? CSUM : (bus.in_data == xsum) ? DONE : ERROR;
            DONE, ERROR: state_n = load_req ? HDR0 : state;
            default:     state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            widx           <= '0;
            bcnt           <= '0;
            asm_q          <= '0;
            xsum           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset_n   <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            state        <= state_n;
            bus.imem_we  <= word_end;
            core_reset_n <= state_n == DONE;
            load_done    <= state_n == DONE;
            load_err     <= state_n == ERROR;
            if (restart) begin
                widx <= '0;
                bcnt <= '0;
                xsum <= '0;
            end
            // the checksum byte itself is excluded from the running XOR
            if (acc && state != CSUM) xsum <= xsum ^ bus.in_data;
            if (acc && state == HDR0) cnt[7:0] <= bus.in_data;
            if (acc && state == HDR1) cnt[15:8] <= bus.in_data;
            if (acc && state == DATA) begin
                bcnt  <= bcnt + 2'd1;
                asm_q <= {bus.in_data, asm_q[31:8]};
            end
            if (word_end) begin
                widx           <= widx + 1'b1;
                bus.imem_addr  <= widx[ADDR_W-1:0];
                bus.imem_wdata <= {bus.in_data, asm_q[31:8]};
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream tests of imem_loader against a stream-level model.
module tb_imem_loader;
    localparam int AW = 8;
    logic clk = 0, reset_n = 0, load_req = 0;
    logic core_reset_n, load_done, load_err;
    int total = 0, bad = 0, stall_pct = 0;
    logic [7:0]    stim[$];
    logic [31:0]   words[$];
    logic [31:0]   exp_w[$];
    bit            exp_done, exp_err;
    logic [AW-1:0] got_a[$];
    logic [31:0]   got_w[$];

    imem_loader_if #(.ADDR_W(AW)) bus ();
    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .load_req(load_req),
        .core_reset_n(core_reset_n), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.imem_we === 1'b1) begin
        got_a.push_back(bus.imem_addr);
        got_w.push_back(bus.imem_wdata);
    end

    function automatic void make_stream(input bit corrupt);
        logic [7:0] x = 0;
        int n = words.size();
        stim.delete();
        stim.push_back(n[7:0]);
        stim.push_back(n[15:8]);
        foreach (words[i]) for (int k = 0; k < 4; k++) stim.push_back(words[i][8*k+:8]);
        foreach (stim[i]) x ^= stim[i];
        stim.push_back(corrupt ? ~x : x);
    endfunction

    // stream-level reference: decode header, slice payload into words, verify XOR
    function automatic void build_expect();
        int n = {stim[1], stim[0]};
        logic [7:0] x = 0;
        exp_w.delete();
        if (n > (1 << AW)) begin
            exp_done = 0;
            exp_err  = 1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_w.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
        for (int i = 0; i < 2 + 4 * n; i++) x ^= stim[i];
        exp_done = stim[2+4*n] == x;
        exp_err  = !exp_done;
    endfunction

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t = 0;
        bus.in_valid = 1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = bus.in_ready === 1'b1;
        @(negedge clk);
        bus.in_valid = 0;
    endtask

    task automatic send_stim(input int upto);
        bit ok;
        for (int i = 0; i < upto; i++) begin
            if ($urandom_range(0, 99) < stall_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(stim[i], ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL send byte %0d: in_ready=0 after 50 cycles, need 1", i);
                return;
            end
        end
    endtask

    task automatic pulse_req(input int cycles);
        load_req = 1;
        repeat (cycles) @(negedge clk);
        load_req = 0;
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.in_ready !== 0) begin bad++; $display("FAIL rst in_ready: got %b need 0", bus.in_ready); end
        total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin bad++; $display("FAIL rst imem: we=%b addr=%h wdata=%h need 0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        total++; if ({core_reset_n, load_done, load_err} !== 3'b000) begin bad++; $display("FAIL rst status: got %b need 000", {core_reset_n, load_done, load_err}); end
        reset_n = 1;
        #1;
        total++; if (bus.in_ready !== 0) begin bad++; $display("FAIL idle in_ready: got %b need 0", bus.in_ready); end
        @(negedge clk);
        total++; if (bus.in_ready !== 1) begin bad++; $display("FAIL hdr0 in_ready: got %b need 1", bus.in_ready); end
    endtask

    task automatic test_single_word();
        got_a.delete(); got_w.delete();
        stim = '{8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h32};
        send_stim(stim.size());
        total++; if (got_w.size() !== 1) begin bad++; $display("FAIL single count: got %0d need 1", got_w.size()); end
        if (got_w.size() > 0) begin
            total++; if (got_a[0] !== 0 || got_w[0] !== 32'h00A00093) begin bad++; $display("FAIL single word: got %h@%h need 00a00093@00", got_w[0], got_a[0]); end
            total++; if (got_w[0][31:20] !== 12'd10) begin bad++; $display("FAIL single imm: got %0d need 10", got_w[0][31:20]); end
        end
        total++; if ({load_done, core_reset_n, load_err} !== 3'b110) begin bad++; $display("FAIL single status: got %b need 110", {load_done, core_reset_n, load_err}); end
    endtask

    task automatic test_bad_csum();
        pulse_req(1);
        total++; if (core_reset_n !== 0 || load_done !== 0) begin bad++; $display("FAIL restart drop: core_reset_n=%b done=%b need 0 0", core_reset_n, load_done); end
        got_a.delete(); got_w.delete();
        stim = '{8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h33};
        send_stim(stim.size());
        total++; if (got_w.size() !== 1 || got_a[0] !== 0 || got_w[0] !== 32'h00A00093) begin bad++; $display("FAIL badcs write: count=%0d need 1 word 00a00093@0", got_w.size()); end
        total++; if ({load_err, load_done, core_reset_n, bus.in_ready} !== 4'b1000) begin bad++; $display("FAIL badcs status: got %b need 1000", {load_err, load_done, core_reset_n, bus.in_ready}); end
        repeat (3) @(negedge clk);
        total++; if (load_err !== 1 || bus.in_ready !== 0) begin bad++; $display("FAIL badcs hold: err=%b in_ready=%b need 1 0", load_err, bus.in_ready); end
    endtask

    task automatic test_zero_and_oversize();
        pulse_req(1);
        got_a.delete(); got_w.delete();
        stim = '{8'h00, 8'h00, 8'h00};
        send_stim(stim.size());
        total++; if (got_w.size() !== 0 || {load_done, load_err} !== 2'b10) begin bad++; $display("FAIL zero len: writes=%0d done/err=%b need 0 10", got_w.size(), {load_done, load_err}); end
        pulse_req(1);
        stim = '{8'h01, 8'h01};
        send_stim(2);
        total++; if ({load_err, load_done, core_reset_n, bus.in_ready} !== 4'b1000 || got_w.size() !== 0) begin bad++; $display("FAIL oversize: status=%b writes=%0d need 1000 0", {load_err, load_done, core_reset_n, bus.in_ready}, got_w.size()); end
    endtask

    task automatic test_full_capacity();
        pulse_req(1);
        got_a.delete(); got_w.delete();
        words.delete();
        for (int i = 0; i < (1 << AW); i++) words.push_back(i);
        make_stream(0);
        stall_pct = 50;
        send_stim(stim.size());
        stall_pct = 0;
        total++; if (got_w.size() !== (1 << AW)) begin bad++; $display("FAIL full count: got %0d need %0d", got_w.size(), 1 << AW); end
        for (int i = 0; i < got_w.size() && i < (1 << AW); i++) begin
            total++; if (got_a[i] !== AW'(i) || got_w[i] !== i) begin bad++; $display("FAIL full word %0d: got %h@%h need %h@%h", i, got_w[i], got_a[i], i, AW'(i)); end
        end
        total++; if ({load_done, core_reset_n, load_err} !== 3'b110) begin bad++; $display("FAIL full status: got %b need 110", {load_done, core_reset_n, load_err}); end
    endtask

    task automatic test_restart();
        pulse_req(3);
        total++; if (core_reset_n !== 0 || bus.in_ready !== 1) begin bad++; $display("FAIL held req: core_reset_n=%b in_ready=%b need 0 1", core_reset_n, bus.in_ready); end
        got_a.delete(); got_w.delete();
        random_words($urandom_range(2, 20));
        make_stream(0);
        build_expect();
        stall_pct = 30;
        send_stim(stim.size());
        stall_pct = 0;
        total++; if (got_w.size() !== exp_w.size()) begin bad++; $display("FAIL restart count: got %0d need %0d", got_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            total++; if (got_a[i] !== AW'(i) || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL restart word %0d: got %h@%h need %h", i, got_w[i], got_a[i], exp_w[i]); end
        end
        total++; if ({load_done, load_err, core_reset_n} !== {exp_done, exp_err, exp_done}) begin bad++; $display("FAIL restart status: got %b need %b", {load_done, load_err, core_reset_n}, {exp_done, exp_err, exp_done}); end
    endtask

    task automatic test_async_reset();
        pulse_req(1);
        random_words(5);
        make_stream(0);
        send_stim(4);
        #2 reset_n = 0;
        #1;
        total++; if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin bad++; $display("FAIL async imem: rdy=%b we=%b addr=%h wdata=%h need 0", bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        total++; if ({core_reset_n, load_done, load_err} !== 3'b000) begin bad++; $display("FAIL async status: got %b need 000", {core_reset_n, load_done, load_err}); end
        @(negedge clk);
        reset_n = 1;
        got_a.delete(); got_w.delete();
        random_words($urandom_range(1, 12));
        make_stream($urandom_range(0, 1) == 1);
        build_expect();
        stall_pct = 40;
        send_stim(stim.size());
        stall_pct = 0;
        total++; if (got_w.size() !== exp_w.size()) begin bad++; $display("FAIL reload count: got %0d need %0d", got_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            total++; if (got_a[i] !== AW'(i) || got_w[i] !== exp_w[i]) begin bad++; $display("FAIL reload word %0d: got %h@%h need %h", i, got_w[i], got_a[i], exp_w[i]); end
        end
        total++; if ({load_done, load_err, core_reset_n} !== {exp_done, exp_err, exp_done}) begin bad++; $display("FAIL reload status: got %b need %b", {load_done, load_err, core_reset_n}, {exp_done, exp_err, exp_done}); end
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data  = 0;
        test_reset();
        test_single_word();
        test_bad_csum();
        test_zero_and_oversize();
        test_full_capacity();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end
endmodule
